fifo_sp_ctrl: RTL
=================

// Module: fifo_sp_ctrl
// PURPOSE
//  Synchronous FIFO controller; sits directly upstream of ram_sp_sr_sw and drives its
//  address/cs/we/oe pins and its shared bidirectional data bus.
//  Turns a push/pop interface into single-port RAM cycles.
//  Reads and writes are serialised because the RAM has one port.
// PARAMETERS
//  DATA_WIDTH  8                 word width; must match the RAM
//  ADDR_WIDTH  8                 RAM address width
//  RAM_DEPTH   1<<ADDR_WIDTH     FIFO capacity in words
// PORTS
//  clk          in     1             clock; all logic on posedge
//  reset        in     1             synchronous, active-high
//  wr_en        in     1             push request
//  wr_data      in     DATA_WIDTH    push word
//  wr_ready     out    1             state==IDLE && !full && !(rd_en && !empty)
//  rd_en        in     1             pop request
//  rd_ready     out    1             state==IDLE && !empty
//  rd_data      out    DATA_WIDTH    popped word, registered
//  rd_valid     out    1             one-cycle strobe; rd_data is valid
//  full         out    1             count==RAM_DEPTH
//  empty        out    1             count==0
//  count        out    ADDR_WIDTH+1  words stored
//  ram_address  out    ADDR_WIDTH    to RAM address
//  ram_cs       out    1             to RAM cs
//  ram_we       out    1             to RAM we
//  ram_oe       out    1             to RAM oe
//  ram_data     inout  DATA_WIDTH    to RAM data; driven only in WR, otherwise 'bz
// BEHAVIOUR
//  Clocking and reset:
//  - One clock, clk. Reset is synchronous and active-high, port reset.
//  - Reset values: state=IDLE, wptr=rptr=0, count=0, empty=1, full=0, rd_valid=0,
//    rd_data=0, ram_cs=ram_we=ram_oe=0, ram_address=0, ram_data released (z).
//  - RAM contents are not cleared.
//  Registers and state:
//  - All ram_* controls are registered; write data is held in a wdata_q register.
//  - FSM states: IDLE, WR, RD1, RD2.
//  IDLE:
//  - Push accepted when wr_en && wr_ready:
//    wdata_q<=wr_data, ram_address<=wptr, cs=1, we=1, oe=0; wptr++, count++; go to WR.
//  - Pop accepted when rd_en && rd_ready:
//    ram_address<=rptr, cs=1, we=0, oe=1; rptr++, count--; go to RD1.
//  - Simultaneous push and pop with !empty: the pop wins, the push is not accepted
//    (wr_ready is low), and the caller must hold wr_en.
//  WR:
//  - ram_data=wdata_q; the RAM writes at this edge.
//  - Next state IDLE with cs=we=0.
//  - One push occupies 2 cycles.
//  RD1:
//  - Controls held; the RAM latches data_out at this edge. Go to RD2.
//  RD2:
//  - Controls held so the RAM drives the bus.
//  - At the edge: rd_data<=ram_data, rd_valid<=1, cs=oe=0; go to IDLE.
//  - rd_valid is high in the 3rd cycle after the accept cycle (a 3-cycle pop).
//  Counters, flags and wrap-around:
//  - count, full and empty update on the accept edge, so a stale flag cannot double-accept.
//  - Pointers are ADDR_WIDTH wide and wrap naturally (RAM_DEPTH-1 -> 0).
//  Illegal requests and reset mid-operation:
//  - wr_en while full and rd_en while empty are ignored; no state change.
//  - reset in any state aborts the operation.
//  - A pop aborted in RD1/RD2 produces no rd_valid, and its word is lost.
//  - A write aborted in WR may or may not land in the RAM; count is 0 regardless.
//  Bus contention:
//  - The controller never drives ram_data while ram_oe=1.
// CONFIGURATION
//  Macro: SPFIFO_ERR_EN
//  - Defined: adds outputs overflow and underflow (1 bit each), both sticky and
//    cleared only by reset.
//    - overflow sets on wr_en && full in IDLE.
//    - underflow sets on rd_en && empty in IDLE.
//  - Undefined: neither port exists, and illegal requests are silently ignored.
// TESTING
//  Bench uses DATA_WIDTH=8, ADDR_WIDTH=4, with ram_sp_sr_sw attached.
//  1. Reset for 2 cycles -> empty=1, full=0, count=0, ram_cs=0, ram_data=z,
//     rd_valid=0, wr_ready=1, rd_ready=0.
//  2. Push 0xA5 then 0x3C, then pop twice -> rd_data 0xA5 then 0x3C.
//     Each rd_valid arrives 3 cycles after its accept; count goes 2->1->0.
//  3. Push 16 words 0x00..0x0F -> full=1, count=16, wr_ready=0.
//     A 17th wr_en is ignored, count stays 16; with SPFIFO_ERR_EN, overflow=1.
//  4. count=3, wr_en=rd_en=1 in the same IDLE cycle -> pop accepted, count=2,
//     then the held push is accepted 3 cycles later, count=3.
//  5. 40 alternating push/pop of an incrementing pattern -> pointers wrap twice and
//     output order is preserved; pop on empty: with SPFIFO_ERR_EN, underflow=1.
//  6. reset asserted in RD1 after a pop of 0x77 -> IDLE next cycle, no rd_valid,
//     count=0, empty=1, ram_cs=0.

Source files
------------

// File: rtl/fifo_sp_ctrl.sv
// fifo_sp_ctrl: synchronous FIFO controller in front of a single-port,
// sync-read/sync-write RAM (ram_sp_sr_sw). Turns push/pop requests into
// serialised RAM cycles: a push takes 2 cycles and a pop takes 3 cycles.
// Optional feature macro: SPFIFO_ERR_EN adds the sticky overflow/underflow outputs.
module fifo_sp_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
`ifdef SPFIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD1  = 2'd2,
        RD2  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_n;

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] wptr_n;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] rptr_n;
    logic [CNT_W-1:0]      count_n;
    logic                  full_n;
    logic                  empty_n;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  cs_n;
    logic                  we_n;
    logic                  oe_n;
    logic [DATA_WIDTH-1:0] rd_data_n;
    logic                  rd_valid_n;
    logic                  push_acc;
    logic                  pop_acc;
`ifdef SPFIFO_ERR_EN
    logic                  overflow_n;
    logic                  underflow_n;
`endif

    // Handshakes: a pending pop always takes priority over a push in IDLE.
    assign rd_ready = (state == IDLE) && !empty;
    assign wr_ready = (state == IDLE) && !full && !(rd_en && !empty);
    assign pop_acc  = rd_en && rd_ready;
    assign push_acc = wr_en && wr_ready;

    // The bus is driven only while the RAM write is in flight (oe is low then).
    assign ram_data = (state == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, pointer/count and RAM control decode.
    always_comb begin
        state_n    = state;
        wptr_n     = wptr;
        rptr_n     = rptr;
        count_n    = count;
        wdata_n    = wdata_q;
        addr_n     = ram_address;
        cs_n       = ram_cs;
        we_n       = ram_we;
        oe_n       = ram_oe;
        rd_data_n  = rd_data;
        rd_valid_n = 1'b0;
`ifdef SPFIFO_ERR_EN
        overflow_n  = overflow;
        underflow_n = underflow;
`endif

        case (state)
            IDLE: begin
                if (pop_acc) begin
                    addr_n  = rptr;
                    cs_n    = 1'b1;
                    we_n    = 1'b0;
                    oe_n    = 1'b1;
                    rptr_n  = rptr + ADDR_WIDTH'(1);
                    count_n = count - CNT_W'(1);
                    state_n = RD1;
                end else if (push_acc) begin
                    wdata_n = wr_data;
                    addr_n  = wptr;
                    cs_n    = 1'b1;
                    we_n    = 1'b1;
                    oe_n    = 1'b0;
                    wptr_n  = wptr + ADDR_WIDTH'(1);
                    count_n = count + CNT_W'(1);
                    state_n = WR;
                end
`ifdef SPFIFO_ERR_EN
                if (wr_en && full) begin
                    overflow_n = 1'b1;
                end
                if (rd_en && empty) begin
                    underflow_n = 1'b1;
                end
`endif
            end
            WR: begin
                // RAM captures ram_data at the edge ending this cycle.
                cs_n    = 1'b0;
                we_n    = 1'b0;
                state_n = IDLE;
            end
            RD1: begin
                // RAM latches its output register at the edge ending this cycle.
                state_n = RD2;
            end
            RD2: begin
                // RAM is driving the bus; capture it and release the RAM.
                rd_data_n  = ram_data;
                rd_valid_n = 1'b1;
                cs_n       = 1'b0;
                oe_n       = 1'b0;
                state_n    = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        full_n  = (count_n == CNT_W'(RAM_DEPTH));
        empty_n = (count_n == CNT_W'(0));
    end

    // Datapath, flag and RAM control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            wdata_q     <= '0;
            ram_address <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            wptr        <= wptr_n;
            rptr        <= rptr_n;
            count       <= count_n;
            full        <= full_n;
            empty       <= empty_n;
            wdata_q     <= wdata_n;
            ram_address <= addr_n;
            ram_cs      <= cs_n;
            ram_we      <= we_n;
            ram_oe      <= oe_n;
            rd_data     <= rd_data_n;
            rd_valid    <= rd_valid_n;
        end
    end

`ifdef SPFIFO_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow_n;
            underflow <= underflow_n;
        end
    end
`endif

endmodule
